int_return_seq: RTL and testbench

Interrupt-return sequencer, the exit-side counterpart of the interrupt entry controller. It tracks nested in-service interrupt levels on a small stack and, when the core executes RETI, injects the instruction sequence that restores SP and PC. It then retires the top in-service level. It sits beside the entry controller and drives the core's injected-instruction path. Its in_service vector feeds back to the entry controller for nesting and masking decisions.

---
 rtl/int_return_seq.sv | 163 ++++++++++++++++
 tb/tb_int_return_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/int_return_seq.sv
// ---------------------------------------------------------------------------
// int_return_seq
//   Interrupt-return sequencer. Keeps a stack of in-service interrupt levels
//   pushed by the entry controller. On RETI it injects INC_SP, POP_PC and a
//   settle NOP into the core instruction path, then pops the top level.
//
// Ports
//   CLK, RST         clock, synchronous active-high reset
//   entry_valid      push strobe from the entry controller
//   entry_level[7:0] level pushed with entry_valid (stored as-is)
//   reti             RETI pulse from the core decoder
//   clr_flags        clears sticky overflow/underflow (a same-cycle set wins)
//   Instruction      injected instruction word (NOP when not injecting)
//   busy             sequencer owns the instruction path
//   in_service       OR of all stacked levels
//   active_level     top-of-stack level, 0 when empty
//   depth            stack occupancy, 0..DEPTH
//   overflow         sticky: push attempted while full
//   underflow        sticky: reti while empty
// ---------------------------------------------------------------------------
module int_return_seq #(
  parameter int          DEPTH        = 8,
  parameter logic [28:0] INSTR_INC_SP = 29'h1600_0F01,
  parameter logic [28:0] INSTR_POP_PC = 29'h05FF_F001,
  parameter logic [28:0] INSTR_NOP    = 29'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   entry_valid,
  input  logic [7:0]             entry_level,
  input  logic                   reti,
  input  logic                   clr_flags,
  output logic [28:0]            Instruction,
  output logic                   busy,
  output logic [7:0]             in_service,
  output logic [7:0]             active_level,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_INC_SP  = 2'd1;
  localparam logic [1:0] S_LOAD_PC = 2'd2;
  localparam logic [1:0] S_RETIRE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d, ovf_set;
  logic          unf_q, unf_d, unf_set;
  logic [7:0]    stack_q [DEPTH];

  logic          push, pop, full, empty;
  logic          wr_en;
  logic [AW-1:0] wr_idx, top_idx;

  assign empty   = (depth_q == '0);
  assign full    = (depth_q == DEPTH_C);
  // Only meaningful when not empty; the truncating cast drops the borrow.
  assign top_idx = AW'(depth_q - DW'(1));

  // -------------------------------------------------------------------------
  // Sequencer FSM. RETI is only looked at in IDLE, so a RETI that arrives
  // while a sequence is running is dropped silently.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unf_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reti) begin
          if (!empty) state_d = S_INC_SP;
          else        unf_set = 1'b1;
        end
      end
      S_INC_SP:  state_d = S_LOAD_PC;
      S_LOAD_PC: state_d = S_RETIRE;
      S_RETIRE:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Stack pointer update. A pop and push in the same cycle overwrite the top
  // slot in place; the stack cannot be full after the pop, so overflow is not
  // raised then. The empty guard on pop keeps the pointer from wrapping.
  // -------------------------------------------------------------------------
  assign push = entry_valid;
  assign pop  = (state_q == S_RETIRE) && !empty;

  always_comb begin
    depth_d = depth_q;
    wr_en   = 1'b0;
    wr_idx  = depth_q[AW-1:0];
    ovf_set = 1'b0;
    if (push && pop) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      if (!full) begin
        wr_en   = 1'b1;
        depth_d = depth_q + DW'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (pop) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // Sticky flags: clear first, then a same-cycle set takes priority.
  assign ovf_d = (ovf_q & ~clr_flags) | ovf_set;
  assign unf_d = (unf_q & ~clr_flags) | unf_set;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage carries no reset; only slots below depth_q are ever read.
  always_ff @(posedge CLK) begin
    if (wr_en && !RST) stack_q[wr_idx] <= entry_level;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    case (state_q)
      S_INC_SP:  Instruction = INSTR_INC_SP;
      S_LOAD_PC: Instruction = INSTR_POP_PC;
      default:   Instruction = INSTR_NOP;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    in_service = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i) < depth_q) in_service = in_service | stack_q[i];
    end
  end

  assign active_level = empty ? 8'h00 : stack_q[top_idx];
  assign depth        = depth_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_int_return_seq.sv
module tb_int_return_seq;

  localparam logic [28:0] INC = 29'h1600_0F01;
  localparam logic [28:0] POP = 29'h05FF_F001;
  localparam logic [28:0] NOP = 29'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST, entry_valid, reti, clr_flags;
  logic [7:0]  entry_level;
  logic [28:0] Instruction;
  logic        busy, overflow, underflow;
  logic [7:0]  in_service, active_level;
  logic [3:0]  depth;

  int_return_seq #(.DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .entry_valid(entry_valid), .entry_level(entry_level),
    .reti(reti), .clr_flags(clr_flags), .Instruction(Instruction), .busy(busy),
    .in_service(in_service), .active_level(active_level), .depth(depth),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          step;
    logic [28:0] ins;
    logic        bsy;
    logic [3:0]  dp;
    logic [7:0]  isv;
    logic [7:0]  act;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_n = 0;

  // Monitor: one snapshot per clock, compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Instruction !== e.ins || busy !== e.bsy || depth !== e.dp ||
            in_service !== e.isv || active_level !== e.act ||
            overflow !== e.ov || underflow !== e.un) begin
          errors++;
          $display("FAIL step%0d: got ins=%h busy=%b depth=%0d isv=%h act=%h ov=%b un=%b, expected ins=%h busy=%b depth=%0d isv=%h act=%h ov=%b un=%b",
                   e.step, Instruction, busy, depth, in_service, active_level, overflow, underflow,
                   e.ins, e.bsy, e.dp, e.isv, e.act, e.ov, e.un);
        end
      end
    end
  end

  // Drive inputs for one cycle and queue the state expected after that edge.
  task automatic s(input logic rst, input logic ev, input logic [7:0] lvl,
                   input logic rt, input logic clr,
                   input logic [28:0] ins, input logic bsy, input logic [3:0] dp,
                   input logic [7:0] isv, input logic [7:0] act,
                   input logic ov, input logic un);
    exp_t e;
    RST = rst; entry_valid = ev; entry_level = lvl; reti = rt; clr_flags = clr;
    step_n++;
    e.step = step_n; e.ins = ins; e.bsy = bsy; e.dp = dp;
    e.isv = isv; e.act = act; e.ov = ov; e.un = un;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  initial begin
    int guard;
    RST = 1'b1; entry_valid = 1'b0; entry_level = 8'h00; reti = 1'b0; clr_flags = 1'b0;
    @(negedge CLK);
    //  rst ev lvl   rt clr  ins  bsy dp isv    act    ov un
    s(1, 0, 8'h00, 0, 0,  NOP, 0, 0, 8'h00, 8'h00, 0, 0);  // reset
    s(0, 1, 8'h04, 0, 0,  NOP, 0, 1, 8'h04, 8'h04, 0, 0);  // push 04
    s(0, 0, 8'h00, 1, 0,  INC, 1, 1, 8'h04, 8'h04, 0, 0);  // reti
    s(0, 0, 8'h00, 0, 0,  POP, 1, 1, 8'h04, 8'h04, 0, 0);
    s(0, 0, 8'h00, 0, 0,  NOP, 1, 1, 8'h04, 8'h04, 0, 0);  // RETIRE
    s(0, 0, 8'h00, 0, 0,  NOP, 0, 0, 8'h00, 8'h00, 0, 0);  // popped
    // nested
    s(0, 1, 8'h01, 0, 0,  NOP, 0, 1, 8'h01, 8'h01, 0, 0);
    s(0, 1, 8'h10, 0, 0,  NOP, 0, 2, 8'h11, 8'h10, 0, 0);
    s(0, 0, 8'h00, 1, 0,  INC, 1, 2, 8'h11, 8'h10, 0, 0);
    s(0, 0, 8'h00, 0, 0,  POP, 1, 2, 8'h11, 8'h10, 0, 0);
    s(0, 0, 8'h00, 0, 0,  NOP, 1, 2, 8'h11, 8'h10, 0, 0);
    s(0, 0, 8'h00, 0, 0,  NOP, 0, 1, 8'h01, 8'h01, 0, 0);
    s(0, 0, 8'h00, 1, 0,  INC, 1, 1, 8'h01, 8'h01, 0, 0);
    s(0, 0, 8'h00, 0, 0,  POP, 1, 1, 8'h01, 8'h01, 0, 0);
    s(0, 0, 8'h00, 0, 0,  NOP, 1, 1, 8'h01, 8'h01, 0, 0);
    s(0, 0, 8'h00, 0, 0,  NOP, 0, 0, 8'h00, 8'h00, 0, 0);
    // underflow
    s(0, 0, 8'h00, 1, 0,  NOP, 0, 0, 8'h00, 8'h00, 0, 1);
    s(0, 0, 8'h00, 0, 0,  NOP, 0, 0, 8'h00, 8'h00, 0, 1);
    s(0, 0, 8'h00, 0, 1,  NOP, 0, 0, 8'h00, 8'h00, 0, 0);
    // fill to DEPTH; last entry is not one-hot and is stored as-is
    s(0, 1, 8'h01, 0, 0,  NOP, 0, 1, 8'h01, 8'h01, 0, 0);
    s(0, 1, 8'h02, 0, 0,  NOP, 0, 2, 8'h03, 8'h02, 0, 0);
    s(0, 1, 8'h04, 0, 0,  NOP, 0, 3, 8'h07, 8'h04, 0, 0);
    s(0, 1, 8'h08, 0, 0,  NOP, 0, 4, 8'h0F, 8'h08, 0, 0);
    s(0, 1, 8'h10, 0, 0,  NOP, 0, 5, 8'h1F, 8'h10, 0, 0);
    s(0, 1, 8'h20, 0, 0,  NOP, 0, 6, 8'h3F, 8'h20, 0, 0);
    s(0, 1, 8'h40, 0, 0,  NOP, 0, 7, 8'h7F, 8'h40, 0, 0);
    s(0, 1, 8'h03, 0, 0,  NOP, 0, 8, 8'h7F, 8'h03, 0, 0);
    s(0, 1, 8'hAA, 0, 0,  NOP, 0, 8, 8'h7F, 8'h03, 1, 0);  // push while full
    // reti with push aligned to RETIRE: top replaced, no new overflow
    s(0, 0, 8'h00, 1, 0,  INC, 1, 8, 8'h7F, 8'h03, 1, 0);
    s(0, 0, 8'h00, 0, 0,  POP, 1, 8, 8'h7F, 8'h03, 1, 0);
    s(0, 0, 8'h00, 0, 0,  NOP, 1, 8, 8'h7F, 8'h03, 1, 0);
    s(0, 1, 8'h80, 0, 0,  NOP, 0, 8, 8'hFF, 8'h80, 1, 0);
    s(0, 1, 8'h55, 0, 1,  NOP, 0, 8, 8'hFF, 8'h80, 1, 0);  // set beats clear
    s(0, 0, 8'h00, 0, 1,  NOP, 0, 8, 8'hFF, 8'h80, 0, 0);
    // second reti during LOAD_PC ignored
    s(0, 0, 8'h00, 1, 0,  INC, 1, 8, 8'hFF, 8'h80, 0, 0);
    s(0, 0, 8'h00, 0, 0,  POP, 1, 8, 8'hFF, 8'h80, 0, 0);
    s(0, 0, 8'h00, 1, 0,  NOP, 1, 8, 8'hFF, 8'h80, 0, 0);
    s(0, 0, 8'h00, 0, 0,  NOP, 0, 7, 8'h7F, 8'h40, 0, 0);
    s(0, 0, 8'h00, 0, 0,  NOP, 0, 7, 8'h7F, 8'h40, 0, 0);
    // RST during LOAD_PC aborts without pop
    s(0, 0, 8'h00, 1, 0,  INC, 1, 7, 8'h7F, 8'h40, 0, 0);
    s(0, 0, 8'h00, 0, 0,  POP, 1, 7, 8'h7F, 8'h40, 0, 0);
    s(1, 0, 8'h00, 0, 0,  NOP, 0, 0, 8'h00, 8'h00, 0, 0);
    s(0, 0, 8'h00, 0, 0,  NOP, 0, 0, 8'h00, 8'h00, 0, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
